// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : MIPS write-back stage. Retires one instruction at a time from
//            MEM, waits for the data-memory response on loads, aligns and
//            extends load data, and drives the register file write port.
// Options  : WB_UNALIGNED_EN - enables the LWL/LWR merge with the old rt
//            value. When undefined, LWL/LWR retire as LW and no rt storage
//            is built.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active low
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_write_en,
  input  logic [4:0]  mem_write_addr,
  input  logic [31:0] mem_result,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_rt_data,
  input  logic [31:0] dram_rdata,
  input  logic        dram_rvalid,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        wb_busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] c_LB  = 3'd0;
  localparam logic [2:0] c_LBU = 3'd1;
  localparam logic [2:0] c_LH  = 3'd2;
  localparam logic [2:0] c_LHU = 3'd3;
`ifdef WB_UNALIGNED_EN
  localparam logic [2:0] c_LWL = 3'd5;
  localparam logic [2:0] c_LWR = 3'd6;
`endif

  state_t      r_state;
  logic        r_we;
  logic [4:0]  r_addr;
  logic [2:0]  r_type;
  logic [1:0]  r_off;
  logic [31:0] w_aligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

`ifdef WB_UNALIGNED_EN
  logic [31:0] r_rt;
  logic [4:0]  w_shl;
  logic [4:0]  w_shr;

  // LWL shifts left by 8*(3-o); 3-o on a 2-bit offset is its bitwise inverse
  assign w_shl = {~r_off, 3'b000};
  assign w_shr = {r_off, 3'b000};
`else
  // rt data only feeds the LWL/LWR merge, which is not built here
  logic w_unused_rt;
  assign w_unused_rt = ^mem_rt_data;
`endif

  // Handshake is only possible in IDLE and never while reset is asserted
  assign mem_ready = rst && (r_state == ST_IDLE);
  assign wb_busy   = (r_state == ST_WAIT);

  // Select the addressed byte and halfword (little-endian)
  always_comb begin
    w_byte = dram_rdata[7:0];
    case (r_off)
      2'd0: w_byte = dram_rdata[7:0];
      2'd1: w_byte = dram_rdata[15:8];
      2'd2: w_byte = dram_rdata[23:16];
      2'd3: w_byte = dram_rdata[31:24];
      default: w_byte = dram_rdata[7:0];
    endcase
    // Halfword misalignment is trapped upstream, so only o[1] matters
    w_half = r_off[1] ? dram_rdata[31:16] : dram_rdata[15:0];
  end

  // Extend / merge the returned word according to the captured load type
  always_comb begin
    w_aligned = dram_rdata;
    case (r_type)
      c_LB:  w_aligned = {{24{w_byte[7]}}, w_byte};
      c_LBU: w_aligned = {24'h000000, w_byte};
      c_LH:  w_aligned = {{16{w_half[15]}}, w_half};
      c_LHU: w_aligned = {16'h0000, w_half};
`ifdef WB_UNALIGNED_EN
      c_LWL: w_aligned = (dram_rdata << w_shl) | (r_rt & ~(32'hFFFF_FFFF << w_shl));
      c_LWR: w_aligned = (dram_rdata >> w_shr) | (r_rt & ~(32'hFFFF_FFFF >> w_shr));
`endif
      default: w_aligned = dram_rdata;  // LW, type 7, and LWL/LWR when disabled
    endcase
  end

  // FSM plus registered write port; write_en defaults low so it pulses once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= 5'd0;
      r_type     <= 3'd0;
      r_off      <= 2'd0;
`ifdef WB_UNALIGNED_EN
      r_rt       <= 32'd0;
`endif
      write_en   <= 1'b0;
      write_addr <= 5'd0;
      write_data <= 32'd0;
    end else begin
      write_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // dram_rvalid is deliberately ignored here
          if (mem_valid) begin
            if (mem_is_load) begin
              r_we    <= mem_write_en && (|mem_write_addr);
              r_addr  <= mem_write_addr;
              r_type  <= mem_load_type;
              r_off   <= mem_addr_lo;
`ifdef WB_UNALIGNED_EN
              r_rt    <= mem_rt_data;
`endif
              r_state <= ST_WAIT;
            end else begin
              write_en   <= mem_write_en && (|mem_write_addr);
              write_addr <= mem_write_addr;
              write_data <= mem_result;
            end
          end
        end
        ST_WAIT: begin
          if (dram_rvalid) begin
            write_en   <= r_we;
            write_addr <= r_addr;
            write_data <= w_aligned;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Directed self-checking bench for wb_stage. Expected LWL/LWR
//            results follow WB_UNALIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write_en;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rt_data;
  logic [31:0] dram_rdata;
  logic        dram_rvalid;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        wb_busy;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_result     (mem_result),
    .mem_is_load    (mem_is_load),
    .mem_load_type  (mem_load_type),
    .mem_addr_lo    (mem_addr_lo),
    .mem_rt_data    (mem_rt_data),
    .dram_rdata     (dram_rdata),
    .dram_rvalid    (dram_rvalid),
    .write_en       (write_en),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .wb_busy        (wb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one load, return data k cycles after acceptance, check the write
  task automatic run_load(input string tag, input logic [2:0] ty, input logic [1:0] off,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input logic [4:0] dest, input int k,
                          input logic exp_we, input logic [31:0] exp_data);
    mem_valid      = 1'b1;
    mem_is_load    = 1'b1;
    mem_write_en   = 1'b1;
    mem_write_addr = dest;
    mem_load_type  = ty;
    mem_addr_lo    = off;
    mem_rt_data    = rt;
    mem_result     = 32'hDEAD_BEEF;
    dram_rdata     = 32'h5A5A_5A5A;
    tick();
    mem_valid = 1'b0;
    for (int i = 1; i <= k; i++) begin
      check({tag, "_ready_low"}, {31'd0, mem_ready}, 32'd0);
      check({tag, "_we_wait"}, {31'd0, write_en}, 32'd0);
      if (i == k) begin
        dram_rvalid = 1'b1;
        dram_rdata  = rdata;
      end
      tick();
    end
    dram_rvalid = 1'b0;
    dram_rdata  = 32'h0;
    check({tag, "_we"}, {31'd0, write_en}, {31'd0, exp_we});
    if (exp_we) begin
      check({tag, "_addr"}, {27'd0, write_addr}, {27'd0, dest});
      check({tag, "_data"}, write_data, exp_data);
    end
    check({tag, "_ready_back"}, {31'd0, mem_ready}, 32'd1);
    tick();
    check({tag, "_we_pulse"}, {31'd0, write_en}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_lwl1, exp_lwr1, exp_lwl0;
`ifdef WB_UNALIGNED_EN
    exp_lwl1 = 32'hCCDD_3344;
    exp_lwr1 = 32'h11AA_BBCC;
    exp_lwl0 = 32'hDD22_3344;
`else
    exp_lwl1 = 32'hAABB_CCDD;
    exp_lwr1 = 32'hAABB_CCDD;
    exp_lwl0 = 32'hAABB_CCDD;
`endif

    rst            = 1'b0;
    mem_valid      = 1'b1;
    mem_write_en   = 1'b1;
    mem_write_addr = 5'd3;
    mem_result     = 32'h1234_5678;
    mem_is_load    = 1'b0;
    mem_load_type  = 3'd0;
    mem_addr_lo    = 2'd0;
    mem_rt_data    = 32'h0;
    dram_rdata     = 32'h0;
    dram_rvalid    = 1'b0;

    // Reset held for 3 cycles with mem_valid asserted
    repeat (3) tick();
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_we",    {31'd0, write_en},  32'd0);
    check("rst_addr",  {27'd0, write_addr}, 32'd0);
    check("rst_data",  write_data, 32'd0);
    check("rst_busy",  {31'd0, wb_busy}, 32'd0);
    mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, mem_ready}, 32'd1);

    // Non-load stream: 5, 0 (suppressed), 7 on consecutive cycles
    mem_valid = 1'b1; mem_write_addr = 5'd5; mem_result = 32'h1111_1111;
    tick();
    check("nl1_we",   {31'd0, write_en}, 32'd1);
    check("nl1_addr", {27'd0, write_addr}, 32'd5);
    check("nl1_data", write_data, 32'h1111_1111);
    mem_write_addr = 5'd0; mem_result = 32'h2222_2222;
    tick();
    check("nl2_we_r0", {31'd0, write_en}, 32'd0);
    mem_write_addr = 5'd7; mem_result = 32'h3333_3333;
    tick();
    check("nl3_we",   {31'd0, write_en}, 32'd1);
    check("nl3_addr", {27'd0, write_addr}, 32'd7);
    check("nl3_data", write_data, 32'h3333_3333);
    mem_valid = 1'b0;
    tick();
    check("idle_we",   {31'd0, write_en}, 32'd0);
    check("idle_hold", write_data, 32'h3333_3333);

    // Non-load with mem_write_en low
    mem_valid = 1'b1; mem_write_en = 1'b0; mem_write_addr = 5'd4;
    tick();
    mem_valid = 1'b0; mem_write_en = 1'b1;
    check("nowe_we", {31'd0, write_en}, 32'd0);

    // dram_rvalid while idle is ignored
    dram_rvalid = 1'b1; dram_rdata = 32'hFFFF_FFFF;
    tick();
    dram_rvalid = 1'b0;
    check("idle_rvalid_we",   {31'd0, write_en}, 32'd0);
    check("idle_rvalid_busy", {31'd0, wb_busy}, 32'd0);

    // Byte / halfword / word loads
    run_load("lb_o2",  3'd0, 2'd2, 32'h0, 32'h80FF_7F01, 5'd9, 3, 1'b1, 32'hFFFF_FFFF);
    run_load("lbu_o2", 3'd1, 2'd2, 32'h0, 32'h80FF_7F01, 5'd9, 3, 1'b1, 32'h0000_00FF);
    run_load("lb_o3",  3'd0, 2'd3, 32'h0, 32'h80FF_7F01, 5'd2, 1, 1'b1, 32'hFFFF_FF80);
    run_load("lbu_o1", 3'd1, 2'd1, 32'h0, 32'h80FF_7F01, 5'd2, 2, 1'b1, 32'h0000_007F);
    run_load("lh_o2",  3'd2, 2'd2, 32'h0, 32'h8001_ABCD, 5'd10, 1, 1'b1, 32'hFFFF_8001);
    run_load("lhu_o2", 3'd3, 2'd2, 32'h0, 32'h8001_ABCD, 5'd10, 1, 1'b1, 32'h0000_8001);
    run_load("lh_o0",  3'd2, 2'd0, 32'h0, 32'h8001_ABCD, 5'd11, 1, 1'b1, 32'hFFFF_ABCD);
    run_load("lw_o3",  3'd4, 2'd3, 32'h0, 32'hCAFE_F00D, 5'd12, 1, 1'b1, 32'hCAFE_F00D);
    run_load("ty7",    3'd7, 2'd1, 32'h0, 32'h0BAD_C0DE, 5'd13, 1, 1'b1, 32'h0BAD_C0DE);
    run_load("lw_r0",  3'd4, 2'd0, 32'h0, 32'h1357_9BDF, 5'd0, 2, 1'b0, 32'h0);

    // Partial-word loads
    run_load("lwl_o1", 3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd14, 1, 1'b1, exp_lwl1);
    run_load("lwr_o1", 3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd15, 1, 1'b1, exp_lwr1);
    run_load("lwl_o0", 3'd5, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 5'd16, 1, 1'b1, exp_lwl0);
    run_load("lwl_o3", 3'd5, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 5'd17, 1, 1'b1, 32'hAABB_CCDD);

    // Reset mid-WAIT drops the outstanding load
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = 3'd4;
    mem_write_addr = 5'd20; mem_write_en = 1'b1;
    tick();
    mem_valid = 1'b0;
    check("midrst_busy_pre", {31'd0, wb_busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy_async", {31'd0, wb_busy}, 32'd0);
    check("midrst_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    rst = 1'b1;
    dram_rvalid = 1'b1; dram_rdata = 32'h7777_7777;
    tick();
    dram_rvalid = 1'b0;
    check("midrst_we",    {31'd0, write_en}, 32'd0);
    check("midrst_ready2", {31'd0, mem_ready}, 32'd1);
    check("midrst_data",  write_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
